// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer
// Driver reaction timer fed by the starting-light sequencer. Arms on
// seq_start, flags a jump start on an early press, otherwise counts BCD
// milliseconds from lights_out to the press and tracks the best time.
// All outputs come straight from registers.

module f1_reaction_timer #(
  parameter logic [15:0] TIMEOUT_BCD = 16'h2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        seq_start,
  input  logic        lights_out,
  input  logic        react,
  input  logic        clr_best,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        result_valid,
  output logic        jump_start,
  output logic        timeout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FOUL   = 3'd4,
    ST_TMO    = 3'd5
  } state_t;

  localparam logic [15:0] BEST_INIT = 16'h9999;

  state_t      state_r;
  state_t      state_s;
  logic        react_q_r;
  logic        press_s;
  logic [15:0] time_r;
  logic [15:0] time_s;
  logic [15:0] time_inc_s;
  logic [15:0] best_r;
  logic [15:0] best_s;
  logic        result_valid_r;
  logic        result_valid_s;
  logic        jump_start_r;
  logic        jump_start_s;
  logic        timeout_r;
  logic        timeout_s;
  logic        busy_r;
  logic        busy_s;
  logic        done_r;
  logic        done_s;

  // Four-digit BCD increment: a digit at 9 rolls to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // A press is the rising edge of the (already synchronised) button level.
  assign press_s    = react & ~react_q_r;
  assign time_inc_s = bcd_inc(time_r);

  // Next-state and next-output decode for the run sequence.
  always_comb begin
    state_s        = state_r;
    time_s         = time_r;
    best_s         = best_r;
    result_valid_s = result_valid_r;
    jump_start_s   = jump_start_r;
    timeout_s      = timeout_r;
    done_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (seq_start) begin
          state_s        = ST_ARMED;
          time_s         = 16'h0000;
          result_valid_s = 1'b0;
          jump_start_s   = 1'b0;
          timeout_s      = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ARMED: begin
        // An early press beats a coincident lights_out.
        if (press_s) begin
          state_s      = ST_FOUL;
          jump_start_s = 1'b1;
          done_s       = 1'b1;
        end else if (seq_start) begin
          state_s        = ST_ARMED;
          time_s         = 16'h0000;
          result_valid_s = 1'b0;
          jump_start_s   = 1'b0;
          timeout_s      = 1'b0;
        end else if (lights_out) begin
          state_s = ST_TIMING;
        end else begin
          state_s = ST_ARMED;
        end
      end

      ST_TIMING: begin
        // Press beats a coincident tick so the displayed time is the pre-tick value.
        if (press_s) begin
          state_s        = ST_DONE;
          result_valid_s = 1'b1;
          done_s         = 1'b1;
          if (time_r < best_r) begin
            best_s = time_r;
          end else begin
            best_s = best_r;
          end
        end else if (seq_start) begin
          state_s = ST_ARMED;
          time_s  = 16'h0000;
        end else if (tick_ms) begin
          time_s = time_inc_s;
          if (time_inc_s == TIMEOUT_BCD) begin
            state_s   = ST_TMO;
            timeout_s = 1'b1;
            done_s    = 1'b1;
          end else begin
            state_s = ST_TIMING;
          end
        end else begin
          state_s = ST_TIMING;
        end
      end

      ST_DONE, ST_FOUL, ST_TMO: begin
        if (seq_start) begin
          state_s        = ST_ARMED;
          time_s         = 16'h0000;
          result_valid_s = 1'b0;
          jump_start_s   = 1'b0;
          timeout_s      = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      default: begin
        state_s        = ST_IDLE;
        time_s         = 16'h0000;
        result_valid_s = 1'b0;
        jump_start_s   = 1'b0;
        timeout_s      = 1'b0;
      end
    endcase

    // Clearing the best time overrides any best update in the same cycle.
    if (clr_best) begin
      best_s = BEST_INIT;
    end else begin
      best_s = best_s;
    end

    busy_s = (state_s == ST_ARMED) || (state_s == ST_TIMING);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      react_q_r      <= 1'b0;
      time_r         <= 16'h0000;
      best_r         <= BEST_INIT;
      result_valid_r <= 1'b0;
      jump_start_r   <= 1'b0;
      timeout_r      <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      react_q_r      <= react;
      time_r         <= time_s;
      best_r         <= best_s;
      result_valid_r <= result_valid_s;
      jump_start_r   <= jump_start_s;
      timeout_r      <= timeout_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
    end
  end

  assign time_bcd     = time_r;
  assign best_bcd     = best_r;
  assign result_valid = result_valid_r;
  assign jump_start   = jump_start_r;
  assign timeout      = timeout_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Testbench for f1_reaction_timer: a fixed vector table, directed runs for
// the long multi-cycle scenarios, and randomized traffic, all checked
// against an integer-millisecond model of the reaction timer.

module tb_f1_reaction_timer;

  localparam int TMO_MS = 2000;

  logic        clk = 1'b0;
  logic        rst_n, tick_ms, seq_start, lights_out, react, clr_best;
  logic [15:0] time_bcd, best_bcd;
  logic        result_valid, jump_start, timeout, busy, done;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model: mode 0 idle, 1 armed, 2 timing, 3 run finished.
  int m_mode, m_ms, m_best;
  bit m_rv, m_js, m_to, m_done, m_prev;

  typedef struct {
    logic        rst_n, tick, seq, lo, react, clr;
    logic [15:0] t, b;
    logic        rv, js, to, bsy, dn;
  } vec_t;

  vec_t tbl [16];

  f1_reaction_timer dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .seq_start(seq_start),
    .lights_out(lights_out), .react(react), .clr_best(clr_best),
    .time_bcd(time_bcd), .best_bcd(best_bcd), .result_valid(result_valid),
    .jump_start(jump_start), .timeout(timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int ms);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((ms / 1000) % 10);
    d2 = 4'((ms / 100) % 10);
    d1 = 4'((ms / 10) % 10);
    d0 = 4'(ms % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_step(input logic r, t, s, l, k, c);
    bit pr;
    if (!r) begin
      m_mode = 0; m_ms = 0; m_best = 9999;
      m_rv = 0; m_js = 0; m_to = 0; m_done = 0; m_prev = 0;
    end else begin
      pr     = k && !m_prev;
      m_prev = k;
      m_done = 0;
      if (m_mode == 0) begin
        if (s) begin m_mode = 1; m_ms = 0; m_rv = 0; m_js = 0; m_to = 0; end
      end else if (m_mode == 1) begin
        if (pr) begin m_mode = 3; m_js = 1; m_done = 1; end
        else if (s) begin m_ms = 0; m_rv = 0; m_js = 0; m_to = 0; end
        else if (l) m_mode = 2;
      end else if (m_mode == 2) begin
        if (pr) begin
          m_mode = 3; m_rv = 1; m_done = 1;
          if (m_ms < m_best) m_best = m_ms;
        end else if (s) begin
          m_mode = 1; m_ms = 0;
        end else if (t) begin
          m_ms = m_ms + 1;
          if (m_ms == TMO_MS) begin m_mode = 3; m_to = 1; m_done = 1; end
        end
      end else begin
        if (s) begin m_mode = 1; m_ms = 0; m_rv = 0; m_js = 0; m_to = 0; end
      end
      if (c) m_best = 9999;
    end
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] dut_word();
    return {3'b000, time_bcd, best_bcd, result_valid, jump_start, timeout, busy, done};
  endfunction

  // One clock: drive inputs, step past the edge, compare against the model.
  task automatic cycle(input logic r, t, s, l, k, c);
    logic m_busy;
    rst_n = r; tick_ms = t; seq_start = s; lights_out = l; react = k; clr_best = c;
    @(posedge clk);
    #1;
    model_step(r, t, s, l, k, c);
    m_busy = (m_mode == 1) || (m_mode == 2);
    chk("model", dut_word(),
        {3'b000, to_bcd(m_ms), to_bcd(m_best), m_rv, m_js, m_to, m_busy, m_done});
  endtask

  task automatic idle1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle1();
    end
  endtask

  task automatic start_timing();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_release();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle1();
  endtask

  initial begin
    logic r_lvl;
    // rst  tick seq  lo   react clr   time      best     rv js to busy done
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 16'h0000,16'h9999, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h9999, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0001,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0002,16'h9999, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 16'h0002,16'h0002, 1'b1,1'b0,1'b0,1'b0,1'b1};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 16'h0002,16'h9999, 1'b1,1'b0,1'b0,1'b0,1'b0};

    rst_n = 1'b0; tick_ms = 1'b0; seq_start = 1'b0;
    lights_out = 1'b0; react = 1'b1; clr_best = 1'b0;

    // Table: reset with button held, fouls, tick/lights_out alignment, clr_best priority.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst_n, tbl[i].tick, tbl[i].seq, tbl[i].lo, tbl[i].react, tbl[i].clr);
      chk($sformatf("table[%0d]", i), dut_word(),
          {3'b000, tbl[i].t, tbl[i].b, tbl[i].rv, tbl[i].js, tbl[i].to, tbl[i].bsy, tbl[i].dn});
    end
    idle1();

    // Normal run at 237 ms.
    start_timing();
    run_ticks(237);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("run237_time", {24'h0, time_bcd}, {24'h0, 16'h0237});
    chk("run237_best", {24'h0, best_bcd}, {24'h0, 16'h0237});
    chk("run237_flags", {35'h0, result_valid, jump_start, timeout, busy, done}, {35'h0, 5'b10001});
    idle1();
    chk("run237_done_pulse", {38'h0, done, busy}, 40'h0);

    // Slower run keeps best.
    start_timing();
    run_ticks(412);
    press_release();
    chk("run412_time", {24'h0, time_bcd}, {24'h0, 16'h0412});
    chk("run412_best", {24'h0, best_bcd}, {24'h0, 16'h0237});

    // Press coincident with tick captures un-incremented count.
    start_timing();
    run_ticks(189);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("run189_time", {24'h0, time_bcd}, {24'h0, 16'h0189});
    chk("run189_best", {24'h0, best_bcd}, {24'h0, 16'h0189});
    idle1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_best", {24'h0, best_bcd}, {24'h0, 16'h9999});

    // BCD carry, then reset mid-TIMING.
    start_timing();
    run_ticks(99);
    chk("carry_0099", {24'h0, time_bcd}, {24'h0, 16'h0099});
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("carry_0100", {24'h0, time_bcd}, {24'h0, 16'h0100});
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_timing", dut_word(), {3'b000, 16'h0000, 16'h9999, 5'b00000});
    idle1();

    // seq_start mid-TIMING abandons the run, then a full timeout.
    start_timing();
    run_ticks(5);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("seq_abort", {23'h0, time_bcd, busy}, {23'h0, 16'h0000, 1'b1});
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(TMO_MS);
    chk("timeout_val", {23'h0, time_bcd, timeout}, {23'h0, 16'h2000, 1'b1});
    press_release();
    chk("timeout_hold", dut_word(), {3'b000, 16'h2000, 16'h9999, 5'b00100});

    // A valid run, then a jump start that must not touch best.
    start_timing();
    run_ticks(50);
    press_release();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("jump_start", dut_word(), {3'b000, 16'h0000, 16'h0050, 5'b01001});
    idle1();

    // Randomized traffic against the model.
    r_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) r_lvl = ~r_lvl;
      cycle(($urandom_range(0, 599) != 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 24) == 0),
            r_lvl,
            ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Driver reaction timer for the F1 starting-light system: the receiving end of the lights-out event produced by the starting-light sequencer. Arms when a light sequence starts and flags a jump start if the driver presses before lights out. Otherwise it counts milliseconds in BCD from lights out to the button press. It keeps a best-time register and presents BCD results directly to the hex-digit decoders.

## Interface
Parameters:
- TIMEOUT_BCD, default 16'h2000: 4-digit BCD ms limit; reaching it without a press ends the run as a timeout.

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- tick_ms, input, 1: one-cycle 1 kHz enable pulse.
- seq_start, input, 1: one-cycle pulse; the light sequence has begun.
- lights_out, input, 1: one-cycle pulse; all lights extinguished (sequencer time-out).
- react, input, 1: driver button level, active-high, already synchronised (KEY inverted upstream).
- clr_best, input, 1: level/pulse; resets best time.
- time_bcd, output, 16: current/last reaction time, 4 BCD digits, [3:0] = ms units.
- best_bcd, output, 16: best valid reaction time, BCD.
- result_valid, output, 1: last run ended with a valid press.
- jump_start, output, 1: last run ended with a press before lights out.
- timeout, output, 1: last run reached TIMEOUT_BCD.
- busy, output, 1: high in ARMED or TIMING.
- done, output, 1: one-cycle pulse on entering DONE, FOUL or TMO.

## Operation
- Press edge: press = react & ~react_q. react_q is a register that resets to 0. A held button never produces a second press.
- States: IDLE, ARMED, TIMING, DONE, FOUL, TMO. Reset state is IDLE.
- IDLE:
  - seq_start -> ARMED; clear time_bcd, result_valid, jump_start and timeout.
  - Presses and lights_out are ignored.
- ARMED:
  - press -> FOUL; set jump_start=1. time_bcd stays 0.
  - lights_out (no press) -> TIMING.
  - press and lights_out in the same cycle -> FOUL (foul has priority).
  - seq_start -> stay ARMED (restart; flags stay clear).
- TIMING:
  - On tick_ms, time_bcd increments in BCD: a digit at 9 goes to 0 and carries into the next digit.
  - press -> DONE; set result_valid=1. If time_bcd < best_bcd, best_bcd <= time_bcd.
  - If press and tick_ms occur together, press wins and the un-incremented value is captured.
  - When the increment would make time_bcd == TIMEOUT_BCD, store that value and go to TMO with timeout=1.
  - seq_start -> ARMED with time cleared (the run is abandoned).
- DONE / FOUL / TMO:
  - Hold all outputs.
  - seq_start -> ARMED, clearing time_bcd and the three flags. best_bcd is kept.
  - Presses and lights_out are ignored.
- clr_best works in any state and sets best_bcd to 16'h9999. If it coincides with a best update, clr_best wins.
- Best compare: unsigned 16-bit compare of BCD words, which is valid for BCD ordering. Equal times do not update best.
- busy is decoded from state. done is registered and high for exactly one cycle per run end.

## Timing
- Reset values: time_bcd=0, best_bcd=16'h9999, result_valid=0, jump_start=0, timeout=0, busy=0, done=0, react_q=0.
- rst_n low at any edge (including mid-TIMING) immediately forces the reset values. best_bcd is also reset.
- Input pulses sampled at edge k give state and outputs visible after edge k (1-cycle latency). No combinational path from input to output.
- The first tick_ms after lights_out counts as 1 ms. A tick_ms in the same cycle as lights_out is not counted.
- Resolution is ±1 ms; the counter never exceeds TIMEOUT_BCD and never wraps.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with react=1 -> all outputs 0, best_bcd=16'h9999. Release with react still high -> no press detected.
- Normal run: seq_start, lights_out, 237 tick_ms, then react rising -> time_bcd=16'h0237, result_valid=1, best_bcd=16'h0237, done high for exactly one cycle, busy=0.
- Jump start: seq_start, then press 10 cycles later -> jump_start=1, time_bcd=0, best_bcd unchanged. Press coincident with lights_out -> also FOUL.
- Timeout: seq_start, lights_out, no press for 2000 ticks -> timeout=1, time_bcd=16'h2000. A later press is ignored.
- Best tracking: run 1 at 237 ms, run 2 at 412 ms -> best stays 16'h0237. Run 3 has press and tick coincident while the count is 0189 -> time_bcd=16'h0189 and best=16'h0189. clr_best -> best=16'h9999.
- BCD carry and abort: count to 0099 then one more tick -> 16'h0100. rst_n low mid-TIMING -> IDLE with reset values. seq_start mid-TIMING -> ARMED with time_bcd=0.
